// File: rtl/pve_l1_mem.sv
// Multi-bank, word-interleaved L1 scratchpad for the PVE cluster.
// Per-bank round-robin arbitration across requestor ports, one-cycle response latency.
module pve_l1_mem #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 8,
  parameter int BANK_DEPTH = 512,
  parameter int DATA_W     = 64,
  localparam int ADDR_W    = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  output logic [NUM_PORTS-1:0]            req_ready_o,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   req_be_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [NUM_PORTS*DATA_W-1:0]     rsp_rdata_o
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int PTR_W  = $clog2(NUM_PORTS);
  localparam int BE_W   = DATA_W / 8;

  // Handshake: a request transfers on a clock edge where req_valid_i[p] & req_ready_o[p];
  // ready is combinational, never high without valid, and the requestor holds its
  // request stable until it sees ready. Responses have no backpressure.

  logic [NUM_PORTS-1:0] bank_req   [NUM_BANKS];
  logic [NUM_PORTS-1:0] bank_gnt   [NUM_BANKS];
  logic [PTR_W-1:0]     rr_ptr_q   [NUM_BANKS];
  logic [PTR_W-1:0]     rr_ptr_d   [NUM_BANKS];
  logic                 bank_en    [NUM_BANKS];
  logic                 bank_we    [NUM_BANKS];
  logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
  logic [BE_W-1:0]      bank_be    [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [NUM_PORTS-1:0] rsp_we_q;
  logic [BANK_W-1:0]    rsp_bank_q [NUM_PORTS];
  logic [DATA_W-1:0]    rsp_hold_q [NUM_PORTS];

  // Arbitration and bank-side request mux; nothing is granted while reset is held.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;
    sum   = '0;
    idx   = '0;
    found = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b]   = '0;
      bank_gnt[b]   = '0;
      rr_ptr_d[b]   = rr_ptr_q[b];
      bank_en[b]    = 1'b0;
      bank_we[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      bank_be[b]    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rst_ni && req_valid_i[p] && (req_addr_i[p*ADDR_W +: BANK_W] == BANK_W'(b)))
          bank_req[b][p] = 1'b1;
      end
      found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        sum = {1'b0, rr_ptr_q[b]} + (PTR_W+1)'(i);
        if (sum >= (PTR_W+1)'(NUM_PORTS))
          sum = sum - (PTR_W+1)'(NUM_PORTS);
        idx = sum[PTR_W-1:0];
        if (!found && bank_req[b][idx]) begin
          found          = 1'b1;
          bank_gnt[b][idx] = 1'b1;
          rr_ptr_d[b]    = (idx == PTR_W'(NUM_PORTS-1)) ? '0 : idx + PTR_W'(1);
        end
      end
      bank_en[b] = found;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          bank_we[b]    = req_we_i[p];
          bank_row[b]   = req_addr_i[p*ADDR_W + BANK_W +: ROW_W];
          bank_wdata[b] = req_wdata_i[p*DATA_W +: DATA_W];
          bank_be[b]    = req_be_i[p*BE_W +: BE_W];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      req_ready_o = req_ready_o | bank_gnt[b];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr_q[b] <= rr_ptr_d[b];
    end
  end

  // Behavioural single-port bank: synchronous read, byte-masked synchronous write.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [BANK_DEPTH];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          for (int i = 0; i < BE_W; i++)
            if (bank_be[b][i]) mem[bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
        end else begin
          rdata_q <= mem[bank_row[b]];
        end
      end
    end
    assign bank_rdata[b] = rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_we_q    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_bank_q[p] <= '0;
        rsp_hold_q[p] <= '0;
      end
    end else begin
      rsp_valid_q <= req_ready_o;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_ready_o[p]) begin
          rsp_we_q[p]   <= req_we_i[p];
          rsp_bank_q[p] <= req_addr_i[p*ADDR_W +: BANK_W];
        end
        if (rsp_valid_q[p]) rsp_hold_q[p] <= rsp_rdata_o[p*DATA_W +: DATA_W];
      end
    end
  end

  // Bank read registers are shared, so each port keeps its own copy of the last response.
  always_comb begin
    rsp_rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_valid_q[p])
        rsp_rdata_o[p*DATA_W +: DATA_W] = rsp_we_q[p] ? '0 : bank_rdata[rsp_bank_q[p]];
      else
        rsp_rdata_o[p*DATA_W +: DATA_W] = rsp_hold_q[p];
    end
  end

  assign rsp_valid_o = rsp_valid_q;

endmodule

// File: tb/tb_pve_l1_mem.sv
// Self-checking bench for pve_l1_mem: vector table plus hand sequences for
// round-robin, read-after-write and reset corner cases, with a response scoreboard.
module tb_pve_l1_mem;

  localparam int NP  = 4;
  localparam int NB  = 8;
  localparam int DEP = 512;
  localparam int DW  = 64;
  localparam int AW  = 12;
  localparam int BEW = DW / 8;

  logic                clk;
  logic                rst_n;
  logic [NP-1:0]       req_valid;
  logic [NP-1:0]       req_ready;
  logic [NP-1:0]       req_we;
  logic [NP*AW-1:0]    req_addr;
  logic [NP*DW-1:0]    req_wdata;
  logic [NP*BEW-1:0]   req_be;
  logic [NP-1:0]       rsp_valid;
  logic [NP*DW-1:0]    rsp_rdata;

  pve_l1_mem #(.NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_DEPTH(DEP), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [NP][$];
  bit            chk_q [NP][$];
  logic [DW-1:0] model_mem [int];

  typedef struct packed {
    logic [NP-1:0]          valid;
    logic [NP-1:0]          we;
    logic [NP-1:0][AW-1:0]  addr;
    logic [NP-1:0][DW-1:0]  wdata;
    logic [NP-1:0][BEW-1:0] be;
    logic [NP-1:0]          exp_ready;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Driver tasks
  task automatic clear_req();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BEW-1:0] be);
    req_valid[p]            = 1'b1;
    req_we[p]               = we;
    req_addr[p*AW +: AW]    = a;
    req_wdata[p*DW +: DW]   = d;
    req_be[p*BEW +: BEW]    = be;
  endtask

  // Record accepted requests: write acks expect 0, reads expect the model word.
  task automatic record_hs(input logic [NP-1:0] rdy);
    int a;
    logic [DW-1:0] w;
    for (int p = 0; p < NP; p++) begin
      if (rdy[p] && !req_valid[p]) begin
        n_checks++;
        $display("FAIL ready_no_valid_p%0d: got ready=1 expected 0", p);
      end
      if (rdy[p] && req_valid[p]) begin
        a = int'(req_addr[p*AW +: AW]);
        if (req_we[p]) begin
          w = model_mem.exists(a) ? model_mem[a] : 'x;
          for (int i = 0; i < BEW; i++)
            if (req_be[p*BEW + i]) w[i*8 +: 8] = req_wdata[p*DW + i*8 +: 8];
          model_mem[a] = w;
          exp_q[p].push_back('0);
          chk_q[p].push_back(1'b1);
        end else begin
          w = model_mem.exists(a) ? model_mem[a] : 'x;
          exp_q[p].push_back(w);
          chk_q[p].push_back(!$isunknown(w));
        end
      end
    end
  endtask

  task automatic check_rsp();
    logic [DW-1:0] e;
    bit c;
    for (int p = 0; p < NP; p++) begin
      if (rsp_valid[p]) begin
        if (exp_q[p].size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp_p%0d: got rsp_valid=1 expected 0", p);
        end else begin
          e = exp_q[p].pop_front();
          c = chk_q[p].pop_front();
          if (c) check($sformatf("rsp_data_p%0d", p), rsp_rdata[p*DW +: DW], e);
        end
      end else if (exp_q[p].size() != 0) begin
        n_checks++;
        $display("FAIL missing_rsp_p%0d: got rsp_valid=0 expected 1", p);
        void'(exp_q[p].pop_front());
        void'(chk_q[p].pop_front());
      end
    end
  endtask

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic tick(output logic [NP-1:0] rdy);
    #1;
    rdy = req_ready;
    record_hs(rdy);
    @(posedge clk);
    #1;
    check_rsp();
    @(negedge clk);
  endtask

  task automatic mk(input int i, input logic [NP-1:0] v, input logic [NP-1:0] we,
                    input logic [NP-1:0] er);
    tbl[i] = '0;
    tbl[i].valid = v;
    tbl[i].we = we;
    tbl[i].exp_ready = er;
  endtask

  task automatic mkp(input int i, input int p, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BEW-1:0] be);
    tbl[i].addr[p]  = a;
    tbl[i].wdata[p] = d;
    tbl[i].be[p]    = be;
  endtask

  initial begin
    logic [NP-1:0] rdy;
    int cnt [NP];
    logic [AW-1:0] rr_addr [NP];

    // Vector table: single-port write/read, byte mask, parallel access, RAW, conflict
    mk(0, 4'b0001, 4'b0001, 4'b0001); mkp(0, 0, 12'h005, 64'h0123_4567_89AB_CDEF, 8'hFF);
    mk(1, 4'b0001, 4'b0000, 4'b0001); mkp(1, 0, 12'h005, '0, '0);
    mk(2, 4'b0001, 4'b0001, 4'b0001); mkp(2, 0, 12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    mk(3, 4'b0001, 4'b0001, 4'b0001); mkp(3, 0, 12'h010, 64'h0, 8'h0F);
    mk(4, 4'b0001, 4'b0000, 4'b0001); mkp(4, 0, 12'h010, '0, '0);
    mk(5, 4'b1111, 4'b1111, 4'b1111);
    for (int p = 0; p < NP; p++) mkp(5, p, AW'(p), 64'h1111_0000_0000_0000 * (p + 1) + 64'(p), 8'hFF);
    mk(6, 4'b1111, 4'b0000, 4'b1111);
    for (int p = 0; p < NP; p++) mkp(6, p, AW'(p), '0, '0);
    mk(7, 4'b0010, 4'b0010, 4'b0010); mkp(7, 1, 12'h003, 64'hA5, 8'hFF);
    mk(8, 4'b0100, 4'b0000, 4'b0100); mkp(8, 2, 12'h003, '0, '0);
    // bank 5 was last granted to port 0, so port 1 wins this conflict
    mk(9, 4'b0011, 4'b0000, 4'b0010); mkp(9, 0, 12'h005, '0, '0); mkp(9, 1, 12'h00D, '0, '0);

    // Reset with random traffic: nothing accepted, no responses
    rst_n = 1'b0;
    clear_req();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = NP'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++) req_addr[p*AW +: AW] = AW'($urandom_range(0, 4095));
      #1;
      check("reset_ready", 64'(req_ready), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_req();
    check("reset_rdata", rsp_rdata[DW-1:0], '0);

    // All ports hammer bank 2: grants rotate 0,1,2,3 starting from port 0
    rr_addr[0] = 12'h002; rr_addr[1] = 12'h00A; rr_addr[2] = 12'h012; rr_addr[3] = 12'h01A;
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int p = 0; p < NP; p++)
        set_req(p, 1'b1, rr_addr[p], 64'hC0DE_0000_0000_0000 | (64'(p) << 16) | 64'(cnt[p]), 8'hFF);
      tick(rdy);
      check($sformatf("rr_grant_c%0d", c), 64'(rdy), 64'(1) << (c % NP));
      for (int p = 0; p < NP; p++) if (rdy[p]) cnt[p]++;
    end
    for (int p = 0; p < NP; p++) check($sformatf("rr_count_p%0d", p), 64'(cnt[p]), 64'd2);
    clear_req();
    for (int p = 0; p < NP; p++) begin
      set_req(0, 1'b0, rr_addr[p], '0, '0);
      tick(rdy);
      check("rr_readback_ready", 64'(rdy), 64'(1));
    end
    clear_req();

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].valid;
      req_we    = tbl[i].we;
      for (int p = 0; p < NP; p++) begin
        req_addr[p*AW +: AW]   = tbl[i].addr[p];
        req_wdata[p*DW +: DW]  = tbl[i].wdata[p];
        req_be[p*BEW +: BEW]   = tbl[i].be[p];
      end
      tick(rdy);
      check($sformatf("vec%0d_ready", i), 64'(rdy), 64'(tbl[i].exp_ready));
      clear_req();
    end
    check("bytemask_model", model_mem[16], 64'hFFFF_FFFF_0000_0000);

    // rdata holds the last response while valid is low
    tick(rdy);
    check("hold_rdata_p2", rsp_rdata[2*DW +: DW], 64'hA5);

    // Reset while a read response is being presented
    set_req(2, 1'b0, 12'h003, '0, '0);
    #1;
    rdy = req_ready;
    record_hs(rdy);
    @(posedge clk);
    #1;
    check("inflight_valid", 64'(rsp_valid[2]), 64'(1));
    check_rsp();
    clear_req();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midreset_rdata_p2", rsp_rdata[2*DW +: DW], '0);
    // A request presented during reset must not be accepted
    set_req(1, 1'b0, 12'h003, '0, '0);
    #1;
    check("midreset_ready", 64'(req_ready), 64'(0));
    clear_req();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(rdy);
      check("post_reset_idle", 64'(rsp_valid), 64'(0));
    end

    // Pointers are back at 0: port 0 beats port 3 on bank 2
    set_req(0, 1'b0, 12'h002, '0, '0);
    set_req(3, 1'b0, 12'h01A, '0, '0);
    tick(rdy);
    check("post_reset_conflict", 64'(rdy), 64'(1));
    req_valid[0] = 1'b0;
    tick(rdy);
    check("post_reset_retry", 64'(rdy), 64'(8));
    clear_req();
    tick(rdy);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pve_l1_mem.md
Name: pve_l1_mem

Overview:
Multi-bank, word-interleaved L1 scratchpad memory for the PVE (programmable vector engine) cluster. It sits between the PVE load/store requestors and the local SRAM banks. Each bank has a round-robin arbiter that resolves conflicts between requestors. Every accepted request returns a single-cycle-latency response.

Parameters:
NUM_PORTS, 4, number of requestor ports (>=2)
NUM_BANKS, 8, number of SRAM banks (power of two)
BANK_DEPTH, 512, words per bank (power of two)
DATA_W, 64, word width in bits (multiple of 8)
ADDR_W, $clog2(NUM_BANKS*BANK_DEPTH), word address width (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assertion, active-low
req_valid_i  in  NUM_PORTS  per-port request valid
req_ready_o  out  NUM_PORTS  per-port request accepted this cycle
req_we_i  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
req_addr_i  in  NUM_PORTS x ADDR_W  per-port word address
req_wdata_i  in  NUM_PORTS x DATA_W  per-port write data
req_be_i  in  NUM_PORTS x DATA_W/8  per-port byte enables (writes only)
rsp_valid_o  out  NUM_PORTS  per-port response valid
rsp_rdata_o  out  NUM_PORTS x DATA_W  per-port read data

Behaviour:
- Address map:
  - bank = addr[$clog2(NUM_BANKS)-1:0]
  - row = addr[ADDR_W-1:$clog2(NUM_BANKS)]
  - Consecutive words therefore fall in consecutive banks.
- Handshake:
  - A request transfers when req_valid_i & req_ready_o.
  - req_ready_o is combinational from the valids, addresses and arbiter state.
  - req_ready_o is 0 when the port's valid is 0.
  - A requestor must hold valid, address, data, we and be stable until ready is seen.
- Arbitration:
  - Each bank grants at most one port per cycle.
  - Ports targeting different banks are all granted in the same cycle; there is no cross-bank limit.
  - Each bank has its own round-robin pointer. Priority starts at the pointer and wraps modulo NUM_PORTS.
  - After a grant to port p, the bank's pointer becomes (p+1) mod NUM_PORTS.
  - The pointer is unchanged in cycles with no grant.
- Write:
  - Only bytes with be=1 are updated at bank/row on the accepting clock edge.
  - be=0 on all bytes is legal and leaves memory unchanged.
- Read: returns the full word.
- Response timing:
  - rsp_valid_o[p] is 1 exactly one cycle after port p's handshake, for one cycle per accepted request.
  - Back-to-back handshakes give back-to-back responses.
  - There is no response backpressure.
- Read data:
  - For reads, rsp_rdata_o[p] holds the stored word.
  - For write acks, rsp_rdata_o[p] = 0.
  - rsp_rdata_o holds its last value while rsp_valid_o = 0.
- Same-bank ordering:
  - Write then read of the same address in consecutive cycles: the read returns the new data.
  - Reads and writes never hit the same bank in the same cycle because the arbiter allows one access per bank per cycle.
- Reset:
  - On rst_ni low, immediately force rsp_valid_o = 0, rsp_rdata_o = 0 and all round-robin pointers = 0 (port 0 highest priority).
  - Responses pending at reset are dropped.
  - Memory contents are not reset; reading an unwritten word returns undefined data, and the bench must not check it.
- Out-of-range: none are possible, because every ADDR_W value maps to a valid bank/row.
- Bank storage: one behavioural single-port array per bank, with synchronous read and synchronous byte-masked write. It must be replaceable by an SRAM macro with 1-cycle read latency.

Test Plan:
1. Reset: hold rst_ni=0 for 5 cycles with random valids -> req_ready_o=0 and rsp_valid_o=0 throughout; after release, port 0 wins the first conflict.
2. Single-port write/read: port 0 writes 0x0123_4567_89AB_CDEF to addr 0x005 with be=0xFF, then reads addr 0x005 -> ack rsp_valid one cycle after the write with rdata=0; read response one cycle after the read with 0x0123456789ABCDEF.
3. Byte mask: write 0xFFFF_FFFF_FFFF_FFFF to addr 0x010, then write 0x0 with be=0x0F, then read -> 0xFFFFFFFF00000000.
4. Parallel conflict-free: ports 0-3 read addrs 0,1,2,3 (banks 0-3) in one cycle -> all four ready that cycle, all four rsp_valid the next cycle with the correct data.
5. Bank conflict round-robin: all four ports continuously request bank 2 (addrs 0x002, 0x00A, 0x012, 0x01A) -> grants in order 0,1,2,3,0; each port is granted exactly once per 4 cycles.
6. Read-after-write and reset mid-operation: port 1 writes 0xA5 to addr 0x003, then port 2 reads addr 0x003 in the next cycle -> read returns 0xA5. Assert rst_ni with a read in flight -> rsp_valid_o drops immediately and no response appears after release.
